regfile_write_arbiter: RTL and testbench



---
 rtl/rv32i_pkg.sv | 7 +
 rtl/regfile_write_arbiter_if.sv | 25 ++
 rtl/rr_arbiter_2.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 86 ++++++++
 tb/tb_regfile_write_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants used by the writeback arbiters.
package rv32i_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Valid/ready writeback request bundle for the two register-file writers.
interface regfile_write_arbiter_if
  import rv32i_pkg::*;
#(
  parameter int DW = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [REG_ADDR_W-1:0] req0_reg;
  logic [DW-1:0]         req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [REG_ADDR_W-1:0] req1_reg;
  logic [DW-1:0]         req1_data;

  modport master (
    output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; pointer moves only when a grant is actually taken.
module rr_arbiter_2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       xfer,
  output logic [1:0] grant,
  output logic       prio
);
  logic prio_d, prio_q;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Favour the other requester after whoever just won.
  always_comb begin
    prio_d = prio_q;
    if (xfer) prio_d = ~grant[1];
  end

  always_ff @(posedge clock) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  assign prio = prio_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU and load/CSR writeback paths.
module regfile_write_arbiter
  import rv32i_pkg::*;
#(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_write_arbiter_if.slave req,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [XLEN-1:0]       write_data,
  output logic                  write_enable,
  output logic                  last_grant,
  output logic [CNT_W-1:0]      contention_count
);
  logic [1:0] valid, grant;
  logic       xfer, sel, prio;

  logic [REG_ADDR_W-1:0] write_reg_d, write_reg_q;
  logic [XLEN-1:0]       write_data_d, write_data_q;
  logic                  write_enable_d, write_enable_q;
  logic                  last_grant_d, last_grant_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;

  assign valid = {req.req1_valid, req.req0_valid};
  assign xfer  = |(valid & grant);
  assign sel   = grant[1];

  rr_arbiter_2 u_arb (
    .clock (clock),
    .reset (reset),
    .valid (valid),
    .xfer  (xfer),
    .grant (grant),
    .prio  (prio)
  );

  assign req.req0_ready = grant[0];
  assign req.req1_ready = grant[1];

  always_comb begin
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    write_enable_d = 1'b0;
    last_grant_d   = last_grant_q;
    if (xfer) begin
      write_reg_d    = sel ? req.req1_reg  : req.req0_reg;
      write_data_d   = sel ? req.req1_data : req.req0_data;
      // x0 writes are still accepted so the requester can retire them.
      write_enable_d = (write_reg_d != ZERO_REG);
      last_grant_d   = sel;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (&valid && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      write_reg_q    <= '0;
      write_data_q   <= '0;
      write_enable_q <= 1'b0;
      last_grant_q   <= 1'b0;
      cnt_q          <= '0;
    end else begin
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      write_enable_q <= write_enable_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
    end
  end

  assign write_reg        = write_reg_q;
  assign write_data       = write_data_q;
  assign write_enable     = write_enable_q;
  assign last_grant       = last_grant_q;
  assign contention_count = cnt_q;

  // The pointer is exposed for debug taps on the arbiter; nothing here consumes it.
  logic unused_prio;
  assign unused_prio = prio;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file model.
module tb_regfile_write_arbiter;
  localparam int CNT_W = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_enable;
  logic        last_grant;
  logic [CNT_W-1:0] contention_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf [32];

  regfile_write_arbiter_if #(.DW(32)) ifc ();

  regfile_write_arbiter #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .req              (ifc),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .write_enable     (write_enable),
    .last_grant       (last_grant),
    .contention_count (contention_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (write_enable) rf[write_reg] <= write_data;

  // Requester-side protocol: a pending, unaccepted write must stay put.
  logic        p_v0, p_r0, p_v1, p_r1, p_rst;
  logic [4:0]  p_reg0, p_reg1;
  logic [31:0] p_dat0, p_dat1;
  initial begin
    p_v0 = 0; p_r0 = 0; p_v1 = 0; p_r1 = 0; p_rst = 1;
    p_reg0 = 0; p_reg1 = 0; p_dat0 = 0; p_dat1 = 0;
  end
  always @(negedge clock) begin
    if (!p_rst && !reset) begin
      if (p_v0 && !p_r0 && !(ifc.req0_valid && ifc.req0_reg == p_reg0 && ifc.req0_data == p_dat0)) begin
        $display("FAIL hold_req0: valid=%b reg=%0d data=%h required held reg=%0d data=%h",
                 ifc.req0_valid, ifc.req0_reg, ifc.req0_data, p_reg0, p_dat0);
        n_fail++;
      end
      if (p_v1 && !p_r1 && !(ifc.req1_valid && ifc.req1_reg == p_reg1 && ifc.req1_data == p_dat1)) begin
        $display("FAIL hold_req1: valid=%b reg=%0d data=%h required held reg=%0d data=%h",
                 ifc.req1_valid, ifc.req1_reg, ifc.req1_data, p_reg1, p_dat1);
        n_fail++;
      end
    end
    p_rst = reset;
    p_v0 = ifc.req0_valid; p_r0 = ifc.req0_ready; p_reg0 = ifc.req0_reg; p_dat0 = ifc.req0_data;
    p_v1 = ifc.req1_valid; p_r1 = ifc.req1_ready; p_reg1 = ifc.req1_reg; p_dat1 = ifc.req1_data;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.req0_valid = 1'b1; ifc.req0_reg = 5'd20; ifc.req0_data = 32'h2020;
    ifc.req1_valid = 1'b1; ifc.req1_reg = 5'd21; ifc.req1_data = 32'h2121;
    tick();
    tick();
    n_checks++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b00) begin
      $display("FAIL reset_ready: got %b%b required 00", ifc.req0_ready, ifc.req1_ready); n_fail++;
    end
    n_checks++;
    if (write_enable !== 1'b0 || contention_count !== '0) begin
      $display("FAIL reset_state: we=%b cnt=%0d required we=0 cnt=0", write_enable, contention_count); n_fail++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b10) begin
      $display("FAIL reset_first_grant: r0r1=%b%b required 10", ifc.req0_ready, ifc.req1_ready); n_fail++;
    end
    tick();
    ifc.req0_valid = 1'b0;
    #1;
    tick();
    ifc.req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    ifc.req0_valid = 1'b1; ifc.req0_reg = 5'd5; ifc.req0_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (ifc.req0_ready !== 1'b1) begin
      $display("FAIL single_ready: req0_ready=%b required 1", ifc.req0_ready); n_fail++;
    end
    tick();
    ifc.req0_valid = 1'b0;
    #1;
    n_checks++;
    if (write_enable !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF || last_grant !== 1'b0) begin
      $display("FAIL single_write: we=%b reg=%0d data=%h lg=%b required 1 5 deadbeef 0",
               write_enable, write_reg, write_data, last_grant); n_fail++;
    end
    tick();
    n_checks++;
    if (write_enable !== 1'b0 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      $display("FAIL single_idle: we=%b reg=%0d data=%h required 0 5 deadbeef",
               write_enable, write_reg, write_data); n_fail++;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ifc.req0_valid = 1'b1; ifc.req0_reg = 5'd1; ifc.req0_data = 32'h11;
    ifc.req1_valid = 1'b1; ifc.req1_reg = 5'd3; ifc.req1_data = 32'h33;
    #1;
    n_checks++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b10) begin
      $display("FAIL rr_g1: r0r1=%b%b required 10", ifc.req0_ready, ifc.req1_ready); n_fail++;
    end
    tick();
    ifc.req0_reg = 5'd2; ifc.req0_data = 32'h22;
    #1;
    n_checks++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b01 || write_enable !== 1'b1 || write_reg !== 5'd1) begin
      $display("FAIL rr_g2: r0r1=%b%b we=%b reg=%0d required 01 1 1",
               ifc.req0_ready, ifc.req1_ready, write_enable, write_reg); n_fail++;
    end
    tick();
    ifc.req1_reg = 5'd4; ifc.req1_data = 32'h44;
    #1;
    n_checks++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b10 || write_enable !== 1'b1 || write_reg !== 5'd3) begin
      $display("FAIL rr_g3: r0r1=%b%b we=%b reg=%0d required 10 1 3",
               ifc.req0_ready, ifc.req1_ready, write_enable, write_reg); n_fail++;
    end
    tick();
    ifc.req0_valid = 1'b0;
    #1;
    n_checks++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b01 || write_enable !== 1'b1 || write_reg !== 5'd2) begin
      $display("FAIL rr_g4: r0r1=%b%b we=%b reg=%0d required 01 1 2",
               ifc.req0_ready, ifc.req1_ready, write_enable, write_reg); n_fail++;
    end
    tick();
    ifc.req1_valid = 1'b0;
    #1;
    n_checks++;
    if (write_enable !== 1'b1 || write_reg !== 5'd4 || write_data !== 32'h44 || contention_count !== 4'd3) begin
      $display("FAIL rr_last: we=%b reg=%0d data=%h cnt=%0d required 1 4 44 3",
               write_enable, write_reg, write_data, contention_count); n_fail++;
    end
    tick();
    n_checks++;
    if (write_enable !== 1'b0 || last_grant !== 1'b1) begin
      $display("FAIL rr_idle: we=%b lg=%b required 0 1", write_enable, last_grant); n_fail++;
    end
  endtask

  task automatic test_x0();
    ifc.req1_valid = 1'b1; ifc.req1_reg = 5'd0; ifc.req1_data = 32'h1234;
    #1;
    n_checks++;
    if (ifc.req1_ready !== 1'b1) begin
      $display("FAIL x0_ready: req1_ready=%b required 1", ifc.req1_ready); n_fail++;
    end
    tick();
    ifc.req1_valid = 1'b0;
    #1;
    n_checks++;
    if (write_enable !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'h1234 || last_grant !== 1'b1) begin
      $display("FAIL x0_write: we=%b reg=%0d data=%h lg=%b required 0 0 1234 1",
               write_enable, write_reg, write_data, last_grant); n_fail++;
    end
  endtask

  task automatic test_same_dest();
    do_reset();
    ifc.req0_valid = 1'b1; ifc.req0_reg = 5'd9; ifc.req0_data = 32'h99;
    tick();
    ifc.req0_reg = 5'd7; ifc.req0_data = 32'hA;
    ifc.req1_valid = 1'b1; ifc.req1_reg = 5'd7; ifc.req1_data = 32'hB;
    #1;
    n_checks++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b01) begin
      $display("FAIL same_first: r0r1=%b%b required 01", ifc.req0_ready, ifc.req1_ready); n_fail++;
    end
    tick();
    ifc.req1_valid = 1'b0;
    #1;
    n_checks++;
    if (ifc.req0_ready !== 1'b1 || write_enable !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'hB) begin
      $display("FAIL same_second: r0=%b we=%b reg=%0d data=%h required 1 1 7 b",
               ifc.req0_ready, write_enable, write_reg, write_data); n_fail++;
    end
    tick();
    ifc.req0_valid = 1'b0;
    #1;
    tick();
    n_checks++;
    if (rf[7] !== 32'hA || rf[9] !== 32'h99) begin
      $display("FAIL same_rf: x7=%h x9=%h required a 99", rf[7], rf[9]); n_fail++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ifc.req0_valid = 1'b1; ifc.req0_reg = 5'd10; ifc.req0_data = 32'h100;
    ifc.req1_valid = 1'b1; ifc.req1_reg = 5'd11; ifc.req1_data = 32'h110;
    for (int i = 0; i < 14; i++) tick();
    n_checks++;
    if (contention_count !== 4'd14) begin
      $display("FAIL sat_14: cnt=%0d required 14", contention_count); n_fail++;
    end
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (contention_count !== 4'd15 || write_enable !== 1'b1) begin
      $display("FAIL sat_hold: cnt=%0d we=%b required 15 1", contention_count, write_enable); n_fail++;
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ifc.req0_ready, ifc.req1_ready} !== 2'b00) begin
      $display("FAIL midrst_ready: r0r1=%b%b required 00", ifc.req0_ready, ifc.req1_ready); n_fail++;
    end
    tick();
    n_checks++;
    if (write_enable !== 1'b0 || contention_count !== 4'd0 || last_grant !== 1'b0) begin
      $display("FAIL midrst_state: we=%b cnt=%0d lg=%b required 0 0 0",
               write_enable, contention_count, last_grant); n_fail++;
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    ifc.req0_valid = 1'b0; ifc.req0_reg = '0; ifc.req0_data = '0;
    ifc.req1_valid = 1'b0; ifc.req1_reg = '0; ifc.req1_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_same_dest();
    test_saturation();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
